// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, almost flags and error pulses.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through read data (latency 0).
// Without it, read data is registered and appears one cycle after the accepted read.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 3,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CNT_W     = ADDR_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_n,
    input  logic                  i_wr_n,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_over_flow,
    output logic                  o_under_flow
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_over_flow;
    logic                  r_under_flow;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_empty;
    logic                  w_full;

    // Accept decisions use the registered count; a read frees a slot so a full FIFO can take a write.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(DEPTH));
        w_rd_ok = ~i_rd_n & ~w_empty;
        w_wr_ok = ~i_wr_n & (~w_full | w_rd_ok);
    end

    // Storage is never reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr_ok)
            r_mem[r_wr_ptr] <= i_data_in;
    end

    // Pointer, occupancy and error-pulse state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_over_flow  <= 1'b0;
            r_under_flow <= 1'b0;
        end else begin
            if (w_rd_ok)
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_wr_ok && !w_rd_ok)
                r_count <= r_count + CNT_W'(1);
            else if (w_rd_ok && !w_wr_ok)
                r_count <= r_count - CNT_W'(1);
            r_over_flow  <= ~i_wr_n & ~w_wr_ok;
            r_under_flow <= ~i_rd_n & ~w_rd_ok;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown combinationally; an empty FIFO shows zero.
    always_comb begin
        o_data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    end
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    // Registered read port: the popped word appears one cycle after the accepted read and then holds.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_data_out <= '0;
        else if (w_rd_ok)
            r_data_out <= r_mem[r_rd_ptr];
    end

    assign o_data_out = r_data_out;
`endif

    // Status flags decoded from the registered count.
    always_comb begin
        o_full         = w_full;
        o_empty        = w_empty;
        o_almost_full  = (r_count >= CNT_W'(AF_THRESH));
        o_almost_empty = (r_count <= CNT_W'(AE_THRESH));
        o_count        = r_count;
        o_over_flow    = r_over_flow;
        o_under_flow   = r_under_flow;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table vectors, directed corner sequences and random traffic against a queue model.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AF = 12;
    localparam int AE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_n = 1'b1;
    logic          wr_n = 1'b1;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, afull, aempty, of, uf;
    logic [4:0]    count;

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_of = 1'b0;
    logic          m_uf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_n(rd_n), .i_wr_n(wr_n), .i_data_in(din),
        .o_data_out(dout), .o_full(full), .o_empty(empty), .o_almost_full(afull),
        .o_almost_empty(aempty), .o_count(count), .o_over_flow(of), .o_under_flow(uf)
    );

    typedef struct {
        logic          rst_n, rd_n, wr_n;
        logic [DW-1:0] din;
        logic [4:0]    cnt;
        logic          emp, ful, ae, af, ovf, unf;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected read data follows the spec: registered pop value, or the head word in fall-through mode.
    function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return q.size() > 0 ? q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    // Apply one clock of stimulus, advance the model, then compare all outputs away from the edge.
    task automatic cyc(input logic r, input logic rd, input logic wr, input logic [DW-1:0] d);
        logic rd_ok, wr_ok;
        rst_n = r; rd_n = rd; wr_n = wr; din = d;
        @(posedge clk);
        if (!r) begin
            q.delete(); m_dout = '0; m_of = 1'b0; m_uf = 1'b0;
        end else begin
            rd_ok = !rd && q.size() > 0;
            wr_ok = !wr && (q.size() < DEPTH || rd_ok);
            m_of = !wr && !wr_ok;
            m_uf = !rd && !rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        check("m_count", 32'(count), 32'(q.size()));
        check("m_full", 32'(full), 32'(q.size() == DEPTH));
        check("m_empty", 32'(empty), 32'(q.size() == 0));
        check("m_afull", 32'(afull), 32'(q.size() >= AF));
        check("m_aempty", 32'(aempty), 32'(q.size() <= AE));
        check("m_over_flow", 32'(of), 32'(m_of));
        check("m_under_flow", 32'(uf), 32'(m_uf));
        check("m_data_out", 32'(dout), 32'(exp_dout()));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h6B, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h7C, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h6B};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7C};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7C};

        // Reset with writes requested, empty read/write collision, short traffic.
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].rst_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].din);
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
            check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].ful));
            check($sformatf("v%0d_aempty", i), 32'(aempty), 32'(vecs[i].ae));
            check($sformatf("v%0d_afull", i), 32'(afull), 32'(vecs[i].af));
            check($sformatf("v%0d_over_flow", i), 32'(of), 32'(vecs[i].ovf));
            check($sformatf("v%0d_under_flow", i), 32'(uf), 32'(vecs[i].unf));
`ifndef FIFO_FWFT_EN
            check($sformatf("v%0d_data_out", i), 32'(dout), 32'(vecs[i].dout));
`endif
        end

        // Fill with 0x00..0x0F, watching almost_full and full edges.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(i));
            if (i == 10) check("fill_afull_low_at_11", 32'(afull), 32'd0);
            if (i == 11) check("fill_afull_high_at_12", 32'(afull), 32'd1);
            if (i == 14) check("fill_not_full_at_15", 32'(full), 32'd0);
        end
        check("fill_full_after_16", 32'(full), 32'd1);

        // Overflow: three rejected writes give three consecutive pulses.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'hEE);
            check("ovf_pulse", 32'(of), 32'd1);
            check("ovf_count_held", 32'(count), 32'd16);
        end
        cyc(1'b1, 1'b1, 1'b1, 8'h00);
        check("ovf_cleared", 32'(of), 32'd0);

        // Full with simultaneous read+write for 20 cycles: wraps pointers, count stays full.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
            check("full_rw_count", 32'(count), 32'd16);
        end

        // Drain: sequence must stay in FIFO order through the wrap.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
        check("drain_last_word", 32'(dout), 32'h53);
`endif
        check("drain_empty", 32'(empty), 32'd1);

`ifdef FIFO_FWFT_EN
        // Fall-through: a single word is visible without a read and vanishes on pop.
        cyc(1'b1, 1'b1, 1'b0, 8'h3C);
        check("fwft_show", 32'(dout), 32'h3C);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("fwft_pop_zero", 32'(dout), 32'h00);
        check("fwft_pop_empty", 32'(empty), 32'd1);
`endif

        // Random traffic in phases biased toward filling, draining and balance, with rare resets.
        for (int p = 0; p < 4; p++) begin
            int wp, rp;
            wp = (p == 0) ? 85 : (p == 1) ? 20 : 55;
            rp = (p == 0) ? 25 : (p == 1) ? 85 : 55;
            for (int i = 0; i < 150; i++) begin
                cyc(($urandom_range(0, 199) != 0),
                    !($urandom_range(0, 99) < rp),
                    !($urandom_range(0, 99) < wp),
                    8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the next-generation buffer for the datapath.
- Configurable data width and depth.
- Occupancy count output, plus programmable almost-full and almost-empty thresholds.
- True simultaneous read/write, including at the full and empty boundaries.
- Registered overflow and underflow error pulses.
It sits between a producer and a consumer in the same clock domain. Both sides use active-low request strobes.

Parameters:
DATA_WIDTH, 8, data bus width in bits (>=1)
DEPTH, 16, number of storage words; must be a power of 2, >=4
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 3, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
(derived) ADDR_W = $clog2(DEPTH); CNT_W = ADDR_W+1

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  reset: one clock; synchronous, active-low (sampled on posedge clk)
rd_n  input  1  read request, active-low
wr_n  input  1  write request, active-low
data_in  input  DATA_WIDTH  write data, sampled when a write is accepted
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  CNT_W  current occupancy, 0..DEPTH
over_flow  output  1  one-cycle pulse: write rejected
under_flow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst_n low at posedge clk): state cleared as follows, and memory contents are not cleared.
  - rd_ptr=0, wr_ptr=0, count=0, data_out=0, over_flow=0, under_flow=0.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0 (for AF_THRESH>0).
  - Reset mid-operation discards all stored words; a request in the reset cycle is ignored.
- Accept rules (evaluated against the registered count at the clock edge):
  - rd_ok = ~rd_n & (count != 0)
  - wr_ok = ~wr_n & ((count != DEPTH) | rd_ok)
  - When full, a simultaneous read+write is accepted: count stays at DEPTH, no over_flow.
  - When empty, a simultaneous read+write: the write is accepted and the read is rejected; count becomes 1 and under_flow pulses.
- Pointers: ADDR_W bits each; increment by 1 per accepted operation and wrap DEPTH-1 -> 0.
- Count update: wr_ok & ~rd_ok gives +1; rd_ok & ~wr_ok gives -1; otherwise unchanged. Count never leaves 0..DEPTH.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the registered count. They are therefore valid in the cycle after the update edge.
- Read data: on rd_ok, data_out <= mem[rd_ptr], visible one cycle after the request edge (latency 1). Otherwise data_out holds its value.
- Write: on wr_ok, mem[wr_ptr] <= data_in.
- Read-during-write to the same address cannot occur except when full. In that case the old word is read.
- Errors (registered, asserted the cycle after the rejected request, high for exactly one cycle per rejected request):
  - over_flow <= ~wr_n & ~wr_ok
  - under_flow <= ~rd_n & ~rd_ok
  - Back-to-back rejected requests hold the flag high continuously.
- No internal FSM beyond the pointer/count state. Arithmetic is unsigned, and the count width CNT_W prevents aliasing at DEPTH.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out = mem[rd_ptr] combinationally whenever empty=0, and forced to 0 when empty=1.
  - An accepted read pops the word displayed in that cycle (latency 0).
  - Accept, count, flag and error rules are unchanged.
- Not defined: registered read with 1-cycle latency, as described in Behaviour.

Test Plan:
1. Reset: hold rst_n=0 for 2 clocks with wr_n=0 -> count=0, empty=1, almost_empty=1, data_out=8'h00, no write stored.
2. Fill/drain: write 16 words 8'h00..8'h0F, then read 16 -> full=1 after the 16th write; almost_full rises as count reaches 12; data_out returns 8'h00..8'h0F in order, each 1 cycle after its read; empty=1 at the end.
3. Overflow: while full, wr_n=0 for 3 cycles with rd_n=1 -> over_flow high for 3 cycles starting the cycle after; count stays 16; contents unchanged on drain.
4. Underflow plus simultaneous access at empty: empty, rd_n=0 and wr_n=0 with data_in=8'hA5 -> under_flow=1 next cycle, count=1; the next read returns 8'hA5.
5. Simultaneous access when full: count=16, rd_n=wr_n=0 for 20 cycles with incrementing data -> count stays 16, no over_flow or under_flow, pointers wrap; the read sequence stays in FIFO order across the wrap.
6. FWFT (FIFO_FWFT_EN defined): write 8'h3C to an empty FIFO -> data_out=8'h3C the cycle after the write with rd_n=1; rd_n=0 pops it, then data_out=8'h00 and empty=1.
